// File: rtl/uart_tx_sched_if.sv
// AXI-Lite config bus between uart_tx_sched (master) and the uart_lite cfg slave.
//   aw*/w*/b* : write address, write data and write response channels
//   ar*/r*    : read address and read data channels
// master modport drives the request side; slave modport is the UART view.
interface uart_tx_sched_if;
    logic        awvalid;
    logic [31:0] awaddr;
    logic        awready;
    logic        wvalid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wready;
    logic        bvalid;
    logic [1:0]  bresp;
    logic        bready;
    logic        arvalid;
    logic [31:0] araddr;
    logic        arready;
    logic        rvalid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rready;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/uart_tx_sched.sv
// Transmit scheduler for uart_lite. Two byte requesters share the UART TX path via
// round-robin arbitration; each accepted byte is pushed by polling the status register
// (0x08) until TX is not full and then writing the TX register (0x04). After reset the
// control register (0x0C) is written once with CTRL_INIT.
// Ports:
//   clk_i, rst_i          : clock, asynchronous active-low reset
//   reqN_valid_i/data_i   : requester N offers a byte
//   reqN_ready_o          : byte from requester N accepted this cycle
//   cfg                   : AXI-Lite master towards the uart_lite cfg slave
//   busy_o                : scheduler not idle
//   err_o / err_clr_i     : sticky error flag (bad response or poll timeout) and its clear
module uart_tx_sched #(
    parameter logic [31:0] CTRL_INIT  = 32'h0000_0003,
    parameter int unsigned POLL_MAX   = 16,
    parameter int unsigned TXFULL_BIT = 3
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       req0_valid_i,
    input  logic [7:0] req0_data_i,
    output logic       req0_ready_o,
    input  logic       req1_valid_i,
    input  logic [7:0] req1_data_i,
    output logic       req1_ready_o,
    uart_tx_sched_if.master cfg,
    output logic       busy_o,
    output logic       err_o,
    input  logic       err_clr_i
);

    typedef enum logic [2:0] {
        StInitW,
        StInitB,
        StIdle,
        StPollAr,
        StPollR,
        StWrW,
        StWrB
    } state_e;

    localparam logic [31:0] AddrTx   = 32'h0000_0004;
    localparam logic [31:0] AddrStat = 32'h0000_0008;
    localparam logic [31:0] AddrCtrl = 32'h0000_000C;
    localparam logic [15:0] PollMaxW = 16'(POLL_MAX);

    state_e      state_q, state_d;
    logic        last_q, last_d;
    logic [7:0]  byte_q, byte_d;
    logic [15:0] poll_cnt_q, poll_cnt_d;
    logic        err_q, err_d;
    logic        aw_done_q, aw_done_d;
    logic        w_done_q, w_done_d;
    logic        awvalid_q, awvalid_d;
    logic [31:0] awaddr_q, awaddr_d;
    logic        wvalid_q, wvalid_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        bready_q, bready_d;
    logic        arvalid_q, arvalid_d;
    logic [31:0] araddr_q, araddr_d;
    logic        rready_q, rready_d;

    logic        grant0, grant1, idle;
    logic        aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic        aw_fin, w_fin;
    logic        err_set;
    logic [15:0] poll_inc;
    logic        tx_full;

    // Only the TX-full bit of the status word matters here.
    logic unused_rdata;
    assign unused_rdata = ^cfg.rdata;

    // last_q names the requester served most recently; the other one is preferred.
    assign grant0 = req0_valid_i & (last_q | ~req1_valid_i);
    assign grant1 = req1_valid_i & (~last_q | ~req0_valid_i);
    assign idle   = (state_q == StIdle);

    assign req0_ready_o = idle & grant0;
    assign req1_ready_o = idle & grant1;

    assign aw_hs = awvalid_q & cfg.awready;
    assign w_hs  = wvalid_q & cfg.wready;
    assign b_hs  = bready_q & cfg.bvalid;
    assign ar_hs = arvalid_q & cfg.arready;
    assign r_hs  = rready_q & cfg.rvalid;

    // A channel counts as finished if it completed earlier or completes now.
    assign aw_fin = aw_done_q | aw_hs;
    assign w_fin  = w_done_q | w_hs;

    assign poll_inc = poll_cnt_q + 16'd1;
    assign tx_full  = cfg.rdata[TXFULL_BIT];

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        byte_d     = byte_q;
        poll_cnt_d = poll_cnt_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        awvalid_d  = awvalid_q;
        awaddr_d   = awaddr_q;
        wvalid_d   = wvalid_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bready_d   = bready_q;
        arvalid_d  = arvalid_q;
        araddr_d   = araddr_q;
        rready_d   = rready_q;
        err_set    = 1'b0;

        case (state_q)
            StInitW, StWrW: begin
                if (state_q == StInitW) begin
                    awaddr_d = AddrCtrl;
                    wdata_d  = CTRL_INIT;
                    wstrb_d  = 4'hF;
                end
                // Raise a channel that has not been issued yet, drop it on its handshake.
                awvalid_d = awvalid_q ? ~cfg.awready : ~aw_done_q;
                wvalid_d  = wvalid_q ? ~cfg.wready : ~w_done_q;
                aw_done_d = aw_fin;
                w_done_d  = w_fin;
                if (aw_fin && w_fin) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    bready_d  = 1'b1;
                    state_d   = (state_q == StInitW) ? StInitB : StWrB;
                end
            end

            StInitB: begin
                if (b_hs) begin
                    bready_d = 1'b0;
                    state_d  = StIdle;
                end
            end

            StIdle: begin
                if (grant0 || grant1) begin
                    byte_d     = grant0 ? req0_data_i : req1_data_i;
                    last_d     = grant1;
                    poll_cnt_d = 16'd0;
                    arvalid_d  = 1'b1;
                    araddr_d   = AddrStat;
                    state_d    = StPollAr;
                end
            end

            StPollAr: begin
                if (ar_hs) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = StPollR;
                end
            end

            StPollR: begin
                if (r_hs) begin
                    rready_d = 1'b0;
                    if (cfg.rresp != 2'b00) begin
                        err_set = 1'b1;
                        state_d = StIdle;
                    end else if (!tx_full) begin
                        // Launch the TX write so both valids are up on entry to WR_W.
                        awvalid_d = 1'b1;
                        awaddr_d  = AddrTx;
                        wvalid_d  = 1'b1;
                        wdata_d   = {24'h0, byte_q};
                        wstrb_d   = 4'h1;
                        state_d   = StWrW;
                    end else begin
                        poll_cnt_d = poll_inc;
                        if (poll_inc == PollMaxW) begin
                            err_set = 1'b1;
                            state_d = StIdle;
                        end else begin
                            arvalid_d = 1'b1;
                            state_d   = StPollAr;
                        end
                    end
                end
            end

            StWrB: begin
                if (b_hs) begin
                    bready_d = 1'b0;
                    err_set  = (cfg.bresp != 2'b00);
                    state_d  = StIdle;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    // A set in the same cycle as a clear wins.
    assign err_d = err_set | (err_q & ~err_clr_i);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= StInitW;
            last_q     <= 1'b1;
            byte_q     <= 8'h00;
            poll_cnt_q <= 16'd0;
            err_q      <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            awvalid_q  <= 1'b0;
            awaddr_q   <= 32'h0;
            wvalid_q   <= 1'b0;
            wdata_q    <= 32'h0;
            wstrb_q    <= 4'h0;
            bready_q   <= 1'b0;
            arvalid_q  <= 1'b0;
            araddr_q   <= 32'h0;
            rready_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            byte_q     <= byte_d;
            poll_cnt_q <= poll_cnt_d;
            err_q      <= err_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            awvalid_q  <= awvalid_d;
            awaddr_q   <= awaddr_d;
            wvalid_q   <= wvalid_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bready_q   <= bready_d;
            arvalid_q  <= arvalid_d;
            araddr_q   <= araddr_d;
            rready_q   <= rready_d;
        end
    end

    assign cfg.awvalid = awvalid_q;
    assign cfg.awaddr  = awaddr_q;
    assign cfg.wvalid  = wvalid_q;
    assign cfg.wdata   = wdata_q;
    assign cfg.wstrb   = wstrb_q;
    assign cfg.bready  = bready_q;
    assign cfg.arvalid = arvalid_q;
    assign cfg.araddr  = araddr_q;
    assign cfg.rready  = rready_q;

    assign busy_o = (state_q != StIdle);
    assign err_o  = err_q;

endmodule
